// File: rtl/hs32_fetch_q.sv
// Instruction prefetch queue: issues sequential word reads from the fetch PC and
// buffers up to DEPTH {pc, inst} entries for decode, with flush/redirect support.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no request outstanding; waiting for queue space
// S_REQ   | request at addr outstanding; response is pushed into the queue
// S_DRAIN | request outstanding across a flush; response will be discarded
module hs32_fetch_q #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          newpc,
  output logic [ADDR_W-1:0]          addr,
  output logic                       reqm,
  input  logic                       rdym,
  input  logic [31:0]                dtrm,
  output logic [31:0]                instd,
  output logic [ADDR_W-1:0]          pcd,
  output logic                       rdyd,
  input  logic                       reqd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fpc, fpc_n, addr_n;
  logic              reqm_n;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [31:0]       mem_inst [DEPTH];

  logic              push, pop, space;
  logic [CW-1:0]     count_nx;
  logic [ADDR_W-1:0] fpc_inc, flush_pc;

  assign rdyd  = (count != '0);
  assign instd = mem_inst[rd_ptr];
  assign pcd   = mem_pc[rd_ptr];

  // Flush overrides both queue ports, so neither push nor pop survives it.
  assign pop      = reqd && rdyd && !flush;
  assign push     = (state == S_REQ) && rdym && !flush;
  assign count_nx = count + CW'(push) - CW'(pop);
  assign space    = (count_nx < DEPTH_C);
  assign fpc_inc  = fpc + ADDR_W'(4);
  assign flush_pc = {newpc[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    addr_n  = addr;
    reqm_n  = reqm;
    if (flush) begin
      fpc_n = flush_pc;
      if (reqm && !rdym) begin
        // The bus address must not move while a request is pending.
        state_n = S_DRAIN;
      end else begin
        // Queue is empty after a flush, so a request can issue immediately.
        state_n = S_REQ;
        reqm_n  = 1'b1;
        addr_n  = flush_pc;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (space) begin
            state_n = S_REQ;
            reqm_n  = 1'b1;
            addr_n  = fpc;
          end
        end
        S_REQ: begin
          if (rdym) begin
            fpc_n = fpc_inc;
            if (space) begin
              addr_n = fpc_inc;
            end else begin
              state_n = S_IDLE;
              reqm_n  = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (rdym) begin
            if (space) begin
              state_n = S_REQ;
              reqm_n  = 1'b1;
              addr_n  = fpc;
            end else begin
              state_n = S_IDLE;
              reqm_n  = 1'b0;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          reqm_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      fpc   <= RESET_PC;
      addr  <= RESET_PC;
      reqm  <= 1'b0;
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      addr  <= addr_n;
      reqm  <= reqm_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= addr;
        mem_inst[wr_ptr] <= dtrm;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nx;
    end
  end

endmodule

// File: tb/tb_hs32_fetch_q.sv
// Directed bench for hs32_fetch_q: memory returns 0xCAFE0000+addr, expected
// addresses, counts and head entries are hand-computed per step.
module tb_hs32_fetch_q;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] newpc;
  logic [31:0] addr;
  logic        reqm;
  logic        rdym;
  logic [31:0] dtrm;
  logic [31:0] instd;
  logic [31:0] pcd;
  logic        rdyd;
  logic        reqd;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dtrm = 32'hCAFE_0000 + addr;

  hs32_fetch_q #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .flush(flush), .newpc(newpc),
    .addr(addr), .reqm(reqm), .rdym(rdym), .dtrm(dtrm),
    .instd(instd), .pcd(pcd), .rdyd(rdyd), .reqd(reqd), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; newpc = '0; rdym = 1'b1; reqd = 1'b0;
    step(); step();
    chk("rst_reqm",  {31'b0, reqm}, 32'd0);
    chk("rst_rdyd",  {31'b0, rdyd}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_instd", instd, 32'd0);
    chk("rst_pcd",   pcd, 32'd0);
    chk("rst_addr",  addr, 32'h1000);

    // Fill: one request per cycle at 0x1000..0x100C.
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("fill_reqm",  {31'b0, reqm}, 32'd1);
      chk("fill_addr",  addr, 32'h1000 + 32'(4 * i));
      chk("fill_count", {29'b0, count}, 32'(i));
      step();
    end
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_reqm",  {31'b0, reqm}, 32'd0);
    chk("full_rdyd",  {31'b0, rdyd}, 32'd1);
    chk("full_instd", instd, 32'hCAFE_1000);
    chk("full_pcd",   pcd, 32'h1000);

    // Single pop from full queue.
    reqd = 1'b1;
    step();
    reqd = 1'b0;
    chk("pop1_pcd",   pcd, 32'h1004);
    chk("pop1_count", {29'b0, count}, 32'd3);
    chk("pop1_reqm",  {31'b0, reqm}, 32'd1);
    chk("pop1_addr",  addr, 32'h1010);
    step();
    chk("refill_count", {29'b0, count}, 32'd4);
    chk("refill_reqm",  {31'b0, reqm}, 32'd0);

    // Streaming: push and pop every cycle, occupancy holds at 3.
    reqd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("stream_pcd",   pcd, 32'h1004 + 32'(4 * i));
      chk("stream_count", {29'b0, count}, 32'd3);
      chk("stream_addr",  addr, 32'h1010 + 32'(4 * i));
    end
    chk("stream_instd", instd, 32'hCAFE_1014);

    // Memory stall for 3 cycles with request at 0x1020 outstanding.
    reqd = 1'b0; rdym = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  addr, 32'h1020);
      chk("stall_reqm",  {31'b0, reqm}, 32'd1);
      chk("stall_count", {29'b0, count}, 32'd3);
    end
    rdym = 1'b1;
    step();
    chk("unstall_count", {29'b0, count}, 32'd4);
    chk("unstall_reqm",  {31'b0, reqm}, 32'd0);

    // Flush to 0x2003 while the 0x1024 request is stalled.
    rdym = 1'b0; reqd = 1'b1;
    step();
    reqd = 1'b0;
    chk("pre_flush_addr", addr, 32'h1024);
    step();
    flush = 1'b1; newpc = 32'h2003;
    step();
    flush = 1'b0;
    chk("flush_rdyd",  {31'b0, rdyd}, 32'd0);
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("drain_addr",  addr, 32'h1024);
    chk("drain_reqm",  {31'b0, reqm}, 32'd1);
    step();
    chk("drain_addr2", addr, 32'h1024);
    rdym = 1'b1;
    step();
    chk("drain_drop_count", {29'b0, count}, 32'd0);
    chk("redirect_addr",    addr, 32'h2000);
    step();
    chk("redirect_rdyd",  {31'b0, rdyd}, 32'd1);
    chk("redirect_pcd",   pcd, 32'h2000);
    chk("redirect_instd", instd, 32'hCAFE_2000);

    // Flush, pop and response in the same cycle.
    flush = 1'b1; newpc = 32'h3000; reqd = 1'b1;
    step();
    flush = 1'b0; reqd = 1'b0;
    chk("sim_count", {29'b0, count}, 32'd0);
    chk("sim_rdyd",  {31'b0, rdyd}, 32'd0);
    chk("sim_addr",  addr, 32'h3000);
    chk("sim_reqm",  {31'b0, reqm}, 32'd1);
    step();
    chk("sim_next_pcd",   pcd, 32'h3000);
    chk("sim_next_count", {29'b0, count}, 32'd1);

    // Async reset mid-request, no clock edge in between.
    #2 reset = 1'b0;
    #1;
    chk("areset_reqm",  {31'b0, reqm}, 32'd0);
    chk("areset_rdyd",  {31'b0, rdyd}, 32'd0);
    chk("areset_count", {29'b0, count}, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("restart_addr", addr, 32'h1000);
    chk("restart_reqm", {31'b0, reqm}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
